alu_seq: RTL and testbench

Parametrised sequential ALU for the datapath's execute stage. Replaces the single-cycle combinational ALU with a WIDTH-bit unit that keeps the existing logic/arithmetic opcodes, adds shifts, unsigned compare, NOR and overflow detection, and runs iterative multiply and divide over multiple cycles. It uses a valid/ready handshake on both input and output, so the control unit can stall the pipeline while a long operation runs.

---
 rtl/alu_seq.sv | 163 ++++++++++++++++
 tb/tb_alu_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU for the execute stage.
// Logic, add/sub, compare and shift ops finish in one cycle.
// MUL/MULHU use an iterative shift-add and DIVU/REMU a restoring divider, one bit per cycle.
// Both input and output use a valid/ready handshake.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [4:0]       ALUop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    localparam int SH = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [SH-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               div_q, div_d;
    logic               hi_q, hi_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               overflow_q, overflow_d;

    logic [WIDTH-1:0]   sum, diff;
    logic [WIDTH-1:0]   aluRes;
    logic               aluOvf;
    logic               isIter;
    logic [SH-1:0]      shamt;

    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] mulNext, divNext, stepNext;

    assign sum   = opA + opB;
    assign diff  = opA - opB;
    assign shamt = opB[SH-1:0];

    // Single-cycle result and signed overflow, computed straight from the operand inputs.
    always_comb begin
        aluRes = '0;
        aluOvf = 1'b0;
        isIter = 1'b0;
        case (ALUop)
            5'b00000: aluRes = opA & opB;
            5'b00010: aluRes = opA | opB;
            5'b00110: aluRes = opA ^ opB;
            5'b01000: aluRes = ~(opA | opB);
            5'b00100: begin
                aluRes = sum;
                aluOvf = (opA[WIDTH-1] == opB[WIDTH-1]) && (sum[WIDTH-1] != opA[WIDTH-1]);
            end
            5'b01100: begin
                aluRes = diff;
                aluOvf = (opA[WIDTH-1] != opB[WIDTH-1]) && (diff[WIDTH-1] != opA[WIDTH-1]);
            end
            5'b01110: aluRes = {{(WIDTH-1){1'b0}}, ($signed(opA) < $signed(opB))};
            5'b01111: aluRes = {{(WIDTH-1){1'b0}}, (opA < opB)};
            5'b10000: aluRes = opA << shamt;
            5'b10010: aluRes = opA >> shamt;
            5'b10011: aluRes = WIDTH'($signed(opA) >>> shamt);
            5'b11000, 5'b11001, 5'b11100, 5'b11101: isIter = 1'b1;
            default: aluRes = '0;
        endcase
    end

    // One iteration of shift-add multiply and of restoring divide.
    // For divide, the upper half of prod_q holds the partial remainder and the lower half the dividend/quotient.
    // A set top bit in trial means the subtraction borrowed, so the old remainder is kept.
    always_comb begin
        mulSum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        mulNext  = {mulSum, prod_q[WIDTH-1:1]};
        trial    = prod_q[2*WIDTH-1:WIDTH-1] - {1'b0, mcand_q};
        divNext  = trial[WIDTH] ? {prod_q[2*WIDTH-2:0], 1'b0}
                                : {trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
        stepNext = div_q ? divNext : mulNext;
    end

    // Next-state logic for the IDLE/BUSY/DONE sequencer and all datapath registers.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prod_d     = prod_q;
        mcand_d    = mcand_q;
        div_d      = div_q;
        hi_d       = hi_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (isIter) begin
                        div_d   = ALUop[2];
                        hi_d    = ALUop[0];
                        prod_d  = ALUop[2] ? {{WIDTH{1'b0}}, opA} : {{WIDTH{1'b0}}, opB};
                        mcand_d = ALUop[2] ? opB : opA;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end else begin
                        result_d   = aluRes;
                        overflow_d = aluOvf;
                        state_d    = DONE;
                    end
                end
            end
            BUSY: begin
                prod_d = stepNext;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == SH'(WIDTH-1)) begin
                    result_d   = hi_q ? stepNext[2*WIDTH-1:WIDTH] : stepNext[WIDTH-1:0];
                    overflow_d = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            prod_q     <= '0;
            mcand_q    <= '0;
            div_q      <= 1'b0;
            hi_q       <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prod_q     <= prod_d;
            mcand_q    <= mcand_d;
            div_q      <= div_d;
            hi_q       <= hi_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = (result_q == '0);
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq.
// It uses directed vectors with hand-derived answers, randomized ops against an arithmetic reference model,
// and hand-written reset/back-pressure/abort sequences.
module tb_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] opA, opB;
    logic [4:0]   ALUop;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;

    int passCount  = 0;
    int totalCount = 0;

    typedef struct {
        string      name;
        logic [4:0] op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] expRes;
        logic       expOvf;
        int         expCyc;
    } vec_t;

    vec_t vecs[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .opA(opA), .opB(opB), .ALUop(ALUop),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .overflow(overflow)
    );

    // Free-running clock with a 10 ns period.
    always #5 clk = ~clk;

    // Watchdog that stops a hung run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Reference model built from the opcode table: plain arithmetic on 64-bit values.
    task automatic refModel(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] res, output logic ovf, output int cyc);
        logic [63:0] p;
        logic [W-1:0] s;
        p   = {32'b0, a} * {32'b0, b};
        res = '0;
        ovf = 1'b0;
        cyc = 1;
        case (op)
            5'b00000: res = a & b;
            5'b00010: res = a | b;
            5'b00110: res = a ^ b;
            5'b01000: res = ~(a | b);
            5'b00100: begin s = a + b; res = s; ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]); end
            5'b01100: begin s = a - b; res = s; ovf = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]); end
            5'b01110: res = ($signed(a) < $signed(b)) ? 1 : 0;
            5'b01111: res = (a < b) ? 1 : 0;
            5'b10000: res = a << b[4:0];
            5'b10010: res = a >> b[4:0];
            5'b10011: res = $signed(a) >>> b[4:0];
            5'b11000: begin res = p[31:0];  cyc = W + 1; end
            5'b11001: begin res = p[63:32]; cyc = W + 1; end
            5'b11100: begin res = (b == 0) ? '1 : a / b; cyc = W + 1; end
            5'b11101: begin res = (b == 0) ? a : a % b; cyc = W + 1; end
            default: res = '0;
        endcase
    endtask

    // Issue one op, measure the cycle offset (T+n) at which out_valid appears, and optionally take the result.
    task automatic applyStimulus(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit handshake, input string name,
                                 output logic [W-1:0] res, output logic ovf, output logic z,
                                 output int cyc);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        ALUop    = op;
        opA      = a;
        opB      = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opA      = $urandom;
        opB      = $urandom;
        ALUop    = 5'($urandom);
        n        = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        cyc = out_valid ? n + 1 : 0;
        res = result;
        ovf = overflow;
        z   = zero;
        if (handshake) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            checkOutput({name, " return"}, {in_ready, out_valid}, 2'b10);
        end
    endtask

    task automatic addVec(input string name, input logic [4:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] r, input logic o, input int c);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.expRes = r; v.expOvf = o; v.expCyc = c;
        vecs.push_back(v);
    endtask

    // Main sequence: reset, directed vectors, random ops, then the corner-case sequences.
    initial begin
        logic [W-1:0] res, expRes;
        logic         ovf, z, expOvf;
        int           cyc, expCyc, highs;
        logic [4:0]   ops[15];
        logic [4:0]   op;
        logic [W-1:0] a, b;

        ops = '{5'b00000, 5'b00010, 5'b00110, 5'b01000, 5'b00100, 5'b01100, 5'b01110, 5'b01111,
                5'b10000, 5'b10010, 5'b10011, 5'b11000, 5'b11001, 5'b11100, 5'b11101};

        addVec("SUB 5-5",        5'b01100, 32'd5,        32'd5,        32'h0,        1'b0, 1);
        addVec("SLT -1,1",       5'b01110, 32'hFFFFFFFF, 32'd1,        32'h1,        1'b0, 1);
        addVec("SLTU -1,1",      5'b01111, 32'hFFFFFFFF, 32'd1,        32'h0,        1'b0, 1);
        addVec("SRA",            5'b10011, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1);
        addVec("SRL",            5'b10010, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 1);
        addVec("NOR 0,0",        5'b01000, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 1);
        addVec("SLL by 0x21",    5'b10000, 32'h1,        32'h21,       32'h2,        1'b0, 1);
        addVec("AND",            5'b00000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1);
        addVec("OR",             5'b00010, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0, 1);
        addVec("XOR",            5'b00110, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0, 1);
        addVec("SUB ovf",        5'b01100, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b1, 1);
        addVec("ADD neg ovf",    5'b00100, 32'h80000000, 32'h80000000, 32'h0,        1'b1, 1);
        addVec("undef 10101",    5'b10101, 32'd123,      32'd456,      32'h0,        1'b0, 1);
        addVec("undef 11010",    5'b11010, 32'd123,      32'd456,      32'h0,        1'b0, 1);
        addVec("MUL 2^16*2^16",  5'b11000, 32'h00010000, 32'h00010000, 32'h0,        1'b0, 33);
        addVec("MULHU 2^16^2",   5'b11001, 32'h00010000, 32'h00010000, 32'h1,        1'b0, 33);
        addVec("MUL -1*-1",      5'b11000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        1'b0, 33);
        addVec("DIVU 100/7",     5'b11100, 32'd100,      32'd7,        32'd14,       1'b0, 33);
        addVec("REMU 100/7",     5'b11101, 32'd100,      32'd7,        32'd2,        1'b0, 33);
        addVec("DIVU 5/0",       5'b11100, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0, 33);
        addVec("REMU 5/0",       5'b11101, 32'd5,        32'd0,        32'd5,        1'b0, 33);

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opA       = '0;
        opB       = '0;
        ALUop     = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset state", {in_ready, out_valid, zero, overflow, result},
                    {1'b1, 1'b0, 1'b1, 1'b0, 32'h0});
        reset = 1'b0;

        // ADD overflow left waiting in DONE, then an asynchronous reset mid-cycle.
        applyStimulus(5'b00100, 32'h7FFFFFFF, 32'h1, 1'b0, "ADD ovf", res, ovf, z, cyc);
        checkOutput("ADD ovf result", {res, ovf, z}, {32'h80000000, 1'b1, 1'b0});
        checkOutput("ADD ovf cycle", cyc, 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async reset", {in_ready, out_valid, zero, overflow, result},
                    {1'b1, 1'b0, 1'b1, 1'b0, 32'h0});
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].name, res, ovf, z, cyc);
            checkOutput({vecs[i].name, " result"}, res, vecs[i].expRes);
            checkOutput({vecs[i].name, " overflow"}, ovf, vecs[i].expOvf);
            checkOutput({vecs[i].name, " zero"}, z, (vecs[i].expRes == 0));
            checkOutput({vecs[i].name, " cycle"}, cyc, vecs[i].expCyc);
        end

        for (int i = 0; i < 150; i++) begin
            op = (($urandom % 8) == 0) ? 5'($urandom) : ops[$urandom % 15];
            a  = $urandom;
            b  = $urandom;
            case ($urandom % 4)
                0: b = $urandom % 16;
                1: b = '0;
                default: ;
            endcase
            refModel(op, a, b, expRes, expOvf, expCyc);
            applyStimulus(op, a, b, 1'b1, "random", res, ovf, z, cyc);
            checkOutput("random result", {op, a, b, res}, {op, a, b, expRes});
            checkOutput("random ovf/zero", {op, ovf, z}, {op, expOvf, (expRes == 0)});
            checkOutput("random cycle", cyc, expCyc);
        end

        // Back-pressure: the result is held for 10 cycles while a competing request is ignored.
        applyStimulus(5'b00110, 32'h12345678, 32'h0F0F0F0F, 1'b0, "bp XOR", res, ovf, z, cyc);
        checkOutput("bp XOR result", res, 32'h1D3B5977);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            ALUop    = 5'b00100;
            opA      = $urandom;
            opB      = $urandom;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("bp hold", {result, in_ready, out_valid}, {32'h1D3B5977, 1'b0, 1'b1});
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkOutput("bp release", {in_ready, out_valid, result}, {1'b1, 1'b0, 32'h1D3B5977});

        // Abort: reset during cycle 10 of a DIVU so it is never emitted, then an ADD must still work.
        @(negedge clk);
        ALUop    = 5'b11100;
        opA      = 32'd1000;
        opB      = 32'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        checkOutput("busy flags", {in_ready, out_valid}, 2'b00);
        #2;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        highs = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) highs++;
        end
        checkOutput("abort no output", highs, 0);
        applyStimulus(5'b00100, 32'd2, 32'd3, 1'b1, "post-abort ADD", res, ovf, z, cyc);
        checkOutput("post-abort ADD", {res, ovf}, {32'd5, 1'b0});
        checkOutput("post-abort cycle", cyc, 1);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
